jtag_mem_ctrl: RTL and testbench

//  Memory-controller stage downstream of the JTAG controller. Runs on the system

---
 rtl/jtag_mem_ctrl.sv | 121 ++++++++++++
 tb/tb_jtag_mem_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/jtag_mem_ctrl.sv
// jtag_mem_ctrl - slow program memory behind a synchronized sel/ready level handshake
// One request per sel pulse; ready stays low for the configured access latency.
module jtag_mem_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WR_LATENCY - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              sel_meta_q, sel_meta_d;
  logic              sel_s_q, sel_s_d;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_wr;

  always_comb begin
    sel_meta_d = sel;
    sel_s_d    = sel_meta_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    rdata_d    = rdata_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_wr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (sel_s_q) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = we ? WR_CNT_INIT : RD_CNT_INIT;
          ready_d = 1'b0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ready_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (we_q) mem_wr = 1'b1;
          else      rdata_d = mem[addr_q];
          ready_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        // A sel still held from the finished request must drop before a new one is accepted.
        if (!sel_s_q) state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_meta_q <= 1'b0;
      sel_s_q    <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      sel_meta_q <= sel_meta_d;
      sel_s_q    <= sel_s_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Memory is not reset; a reset edge suppresses any write that would land on it.
  always_ff @(posedge clk) begin
    if (!rst && mem_wr) mem[addr_q] <= wdata_q;
  end

  assign ready = ready_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_jtag_mem_ctrl.sv
// tb_jtag_mem_ctrl - directed checks of handshake latency, memory contents and reset abort
module tb_jtag_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        we;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        ready;
  logic [15:0] rdata;

  int checks = 0;
  int errors = 0;

  jtag_mem_ctrl #(
    .ADDR_W(8), .DATA_W(16), .RD_LATENCY(2), .WR_LATENCY(4)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .ready(ready), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raise sel and count clk edges until ready is seen low (bounded).
  task automatic req_start(input logic w, input logic [7:0] a, input logic [15:0] d,
                           output int edges);
    we = w; addr = a; wdata = d; sel = 1'b1;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (ready && edges < 20);
  endtask

  // Count cycles ready stays low; also report whether rdata moved meanwhile.
  task automatic req_wait(output int low, output logic rd_stable);
    logic [15:0] r0;
    r0 = rdata;
    rd_stable = 1'b1;
    low = 1;
    forever begin
      @(negedge clk);
      if (ready) break;
      if (rdata !== r0) rd_stable = 1'b0;
      low++;
      if (low > 50) break;
    end
    if (rdata !== r0 && !(!we && ready)) rd_stable = 1'b0;
  endtask

  task automatic req_end();
    sel = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_acc(input logic w, input logic [7:0] a, input logic [15:0] d,
                        output int edges, output int low);
    logic st;
    req_start(w, a, d, edges);
    req_wait(low, st);
    req_end();
  endtask

  int e, l;
  logic stable;
  logic held_ok;

  initial begin
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_rdata", {16'd0, rdata}, 32'd0);
    held_ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (ready !== 1'b1 || rdata !== 16'h0) held_ok = 1'b0;
    end
    chk("idle_hold", {31'd0, held_ok}, 32'd1);

    // 2: write then read back
    do_acc(1'b1, 8'h12, 16'hA5C3, e, l);
    chk("wr_sel_to_busy", e, 3);
    chk("wr_low_cycles", l, 4);
    do_acc(1'b0, 8'h12, 16'h0000, e, l);
    chk("rd_sel_to_busy", e, 3);
    chk("rd_low_cycles", l, 2);
    chk("rd_12", {16'd0, rdata}, 32'h0000A5C3);

    // 3: address boundaries
    do_acc(1'b1, 8'h00, 16'h0001, e, l);
    do_acc(1'b1, 8'hFF, 16'hFFFF, e, l);
    do_acc(1'b0, 8'h00, 16'h0000, e, l);
    chk("rd_00", {16'd0, rdata}, 32'h00000001);
    do_acc(1'b0, 8'hFF, 16'h0000, e, l);
    chk("rd_ff", {16'd0, rdata}, 32'h0000FFFF);
    do_acc(1'b0, 8'h12, 16'h0000, e, l);
    chk("rd_12_again", {16'd0, rdata}, 32'h0000A5C3);

    // 4: sel held long, inputs changed during ACCESS
    req_start(1'b1, 8'h50, 16'h1111, e);
    wdata = 16'h2222;
    addr  = 8'h51;
    req_wait(l, stable);
    chk("hold_low_cycles", l, 4);
    held_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ready !== 1'b1) held_ok = 1'b0;
    end
    chk("hold_ready_high", {31'd0, held_ok}, 32'd1);
    req_end();
    do_acc(1'b0, 8'h50, 16'h0000, e, l);
    chk("rd_50_old_wdata", {16'd0, rdata}, 32'h00001111);

    // 5: rdata holds across a write
    do_acc(1'b1, 8'h40, 16'hBEEF, e, l);
    do_acc(1'b0, 8'h40, 16'h0000, e, l);
    chk("rd_40", {16'd0, rdata}, 32'h0000BEEF);
    req_start(1'b1, 8'h41, 16'h1234, e);
    req_wait(l, stable);
    req_end();
    chk("rdata_stable_wr", {31'd0, stable}, 32'd1);
    chk("rdata_after_wr", {16'd0, rdata}, 32'h0000BEEF);

    // 6: reset aborts a write in its 2nd ACCESS cycle
    do_acc(1'b1, 8'h30, 16'h5555, e, l);
    req_start(1'b1, 8'h30, 16'hAAAA, e);
    @(negedge clk);
    chk("abort_busy", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    sel = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_rdata", {16'd0, rdata}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_acc(1'b0, 8'h30, 16'h0000, e, l);
    chk("rd_30_kept", {16'd0, rdata}, 32'h00005555);
    chk("rd_30_low", l, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
